trv32i_fetch_buffer: RTL and testbench

Instruction fetch stage sitting between the synchronous instruction memory and the TRV32I core. Generates sequential fetch addresses, absorbs the memory's one-cycle read latency, and buffers fetched words in a DEPTH-entry FIFO with a valid/ready handshake toward the core. Handles core redirects (branch/jump) by flushing buffered and in-flight fetches, and flags misaligned redirect targets.

---
 rtl/trv32i_fetch_buffer.sv | 119 +++++++++++
 tb/tb_trv32i_fetch_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trv32i_fetch_buffer.sv
// Fetch stage for TRV32I. It issues sequential fetches to a one-cycle-latency
// instruction memory, queues the returned words, and handles core redirects.
module trv32i_fetch_buffer #(
    parameter int                 B_WIDTH  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [B_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [B_WIDTH-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [B_WIDTH-1:0] redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [B_WIDTH-1:0] out_pc,
    output logic [31:0]        out_inst,
    output logic               out_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, FAULT} state_e;

    state_e             state_q, state_d;
    logic [B_WIDTH-1:0] fpc_q, fpc_d;
    logic               infl_q, infl_d;
    logic [B_WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic               mark_q, mark_d;
    logic [B_WIDTH-1:0] mark_pc_q, mark_pc_d;
    logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [B_WIDTH-1:0] pc_mem   [DEPTH];
    logic [31:0]        inst_mem [DEPTH];
    logic               flt_mem  [DEPTH];

    logic               issue, push, pop, head_vld;
    logic [B_WIDTH-1:0] push_pc;
    logic [31:0]        push_inst;

    // Credit counts the in-flight word so a returning fetch always has a slot.
    assign issue = !rst && (state_q == RUN) && !redirect_valid &&
                   ((cnt_q + CW'(infl_q)) < CW'(DEPTH));

    assign head_vld  = !rst && (cnt_q != '0);
    assign push      = (infl_q || mark_q) && !redirect_valid;
    assign pop       = head_vld && out_ready && !redirect_valid;
    assign push_pc   = mark_q ? mark_pc_q : infl_pc_q;
    assign push_inst = mark_q ? 32'h0 : imem_rdata;

    always_comb begin
        state_d   = state_q;
        fpc_d     = issue ? fpc_q + B_WIDTH'(4) : fpc_q;
        infl_d    = issue;
        infl_pc_d = issue ? fpc_q : infl_pc_q;
        mark_d    = 1'b0;
        mark_pc_d = mark_pc_q;
        rd_d      = rd_q + PW'(pop);
        wr_d      = wr_q + PW'(push);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            if (redirect_pc[1:0] == 2'b00) begin
                fpc_d   = redirect_pc;
                state_d = RUN;
            end else begin
                // The fault marker is queued next cycle, into the freshly flushed FIFO.
                state_d   = FAULT;
                mark_d    = 1'b1;
                mark_pc_d = redirect_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            mark_q    <= 1'b0;
            mark_pc_q <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            mark_q    <= mark_d;
            mark_pc_q <= mark_pc_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_q]   <= push_pc;
            inst_mem[wr_q] <= push_inst;
            flt_mem[wr_q]  <= mark_q;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fpc_q;
    assign out_valid = head_vld;
    assign out_pc    = head_vld ? pc_mem[rd_q]   : '0;
    assign out_inst  = head_vld ? inst_mem[rd_q] : 32'h0;
    assign out_fault = head_vld ? flt_mem[rd_q]  : 1'b0;

endmodule

// File: tb/tb_trv32i_fetch_buffer.sv
// Bench for trv32i_fetch_buffer: an instruction-stream model checked every cycle,
// plus directed scenarios with literal cycle-exact expectations.
module tb_trv32i_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    int vectors = 0;
    int errs    = 0;

    trv32i_fetch_buffer #(.B_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    // Memory image: the word at byte address 4*i holds i.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a >> 2;
    endfunction

    // Garbage on cycles without a request exposes any unrequested capture.
    always @(posedge clk)
        imem_rdata <= imem_req ? memw(imem_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: what the core must see next, independent of buffering/timing.
    logic [31:0] m_pc    = 32'h0;
    logic        m_fault = 1'b0;
    logic        m_mark  = 1'b0;
    logic [31:0] m_mpc   = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            chk("m_req_in_rst", 32'(imem_req), 32'd0);
            chk("m_valid_in_rst", 32'(out_valid), 32'd0);
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_mark  = 1'b0;
        end else begin
            if (redirect_valid) chk("m_req_in_redirect", 32'(imem_req), 32'd0);
            if (m_fault) chk("m_req_in_fault", 32'(imem_req), 32'd0);
            if (imem_req) chk("m_addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (m_fault && !m_mark) begin
                chk("m_stray_valid", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                if (m_fault) begin
                    chk("m_mark_pc", out_pc, m_mpc);
                    chk("m_mark_inst", out_inst, 32'h0);
                    chk("m_mark_fault", 32'(out_fault), 32'd1);
                end else begin
                    chk("m_pc", out_pc, m_pc);
                    chk("m_inst", out_inst, memw(m_pc));
                    chk("m_fault", 32'(out_fault), 32'd0);
                end
            end
            if (redirect_valid) begin
                if (redirect_pc[1:0] == 2'b00) begin
                    m_pc    = redirect_pc;
                    m_fault = 1'b0;
                    m_mark  = 1'b0;
                end else begin
                    m_fault = 1'b1;
                    m_mark  = 1'b1;
                    m_mpc   = redirect_pc;
                end
            end else if (out_valid && out_ready) begin
                if (m_fault) m_mark = 1'b0;
                else         m_pc   = m_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic head(input string name, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic f);
        chk({name, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk({name, "_pc"}, out_pc, pc);
            chk({name, "_inst"}, out_inst, inst);
            chk({name, "_fault"}, 32'(out_fault), 32'(f));
        end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset values and start-up latency with a free-running consumer.
        tick(); tick(); #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_fault", 32'(out_fault), 32'd0);
        tick(); rst = 1'b0; #2;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", 32'(out_valid), 32'd0);
        tick(); #2;
        chk("c1_valid", 32'(out_valid), 32'd0);
        for (int c = 2; c < 10; c++) begin
            tick(); #2;
            head("stream", 1'b1, 32'(4 * (c - 2)), 32'(c - 2), 1'b0);
        end

        // Stalled consumer: exactly DEPTH entries, then drain in order.
        out_ready = 1'b0;
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            #2;
            if (c == 3) chk("stall_c3_req", 32'(imem_req), 32'd1);
            if (c == 4) chk("stall_c4_req", 32'(imem_req), 32'd0);
            if (c == 9) begin
                chk("stall_full_req", 32'(imem_req), 32'd0);
                head("stall_full", 1'b1, 32'h0, 32'h0, 1'b0);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            head("drain", 1'b1, 32'(4 * k), 32'(k), 1'b0);
            if (k == 0) chk("drain_req0", 32'(imem_req), 32'd0);
            if (k == 1) begin
                chk("drain_req1", 32'(imem_req), 32'd1);
                chk("drain_addr1", imem_addr, 32'h10);
            end
            tick();
        end

        // Redirect with three buffered and one in flight.
        out_ready = 1'b0;
        reset_pulse();
        tick(); tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1; #2;
        chk("rd_req_n", 32'(imem_req), 32'd0);
        tick(); redirect_valid = 1'b0; #2;
        chk("rd_req_n1", 32'(imem_req), 32'd1);
        chk("rd_addr_n1", imem_addr, 32'h100);
        chk("rd_valid_n1", 32'(out_valid), 32'd0);
        tick(); #2;
        chk("rd_valid_n2", 32'(out_valid), 32'd0);
        tick(); #2;
        head("rd_n3", 1'b1, 32'h100, 32'h40, 1'b0);
        tick(); #2;
        head("rd_n4", 1'b1, 32'h104, 32'h41, 1'b0);

        // Misaligned redirect, held marker, then recovery.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h102; out_ready = 1'b0;
        tick(); redirect_valid = 1'b0; #2;
        chk("mis_n1_valid", 32'(out_valid), 32'd0);
        chk("mis_n1_req", 32'(imem_req), 32'd0);
        tick(); #2;
        head("mis_n2", 1'b1, 32'h102, 32'h0, 1'b1);
        tick(); out_ready = 1'b1; #2;
        head("mis_n3", 1'b1, 32'h102, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(); #2;
            chk("mis_idle_valid", 32'(out_valid), 32'd0);
            chk("mis_idle_req", 32'(imem_req), 32'd0);
        end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
        chk("rec_req_m", 32'(imem_req), 32'd0);
        tick(); redirect_valid = 1'b0; #2;
        chk("rec_req_m1", 32'(imem_req), 32'd1);
        chk("rec_addr_m1", imem_addr, 32'h200);
        tick(); tick(); #2;
        head("rec_m3", 1'b1, 32'h200, 32'h80, 1'b0);

        // Address wrap at the top of the space.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick(); redirect_valid = 1'b0;
        tick(); tick(); #2;
        head("wrap0", 1'b1, 32'hFFFF_FFF8, 32'h3FFF_FFFE, 1'b0);
        tick(); #2;
        head("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b0);
        tick(); #2;
        head("wrap2", 1'b1, 32'h0, 32'h0, 1'b0);

        // Reset in the middle of a full FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        #2;
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        tick(); rst = 1'b1; out_ready = 1'b1; #2;
        chk("mrst_req", 32'(imem_req), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        tick(); rst = 1'b0; #2;
        chk("mrst_c0_valid", 32'(out_valid), 32'd0);
        chk("mrst_c0_req", 32'(imem_req), 32'd1);
        chk("mrst_c0_addr", imem_addr, 32'h0);
        tick(); #2;
        chk("mrst_c1_valid", 32'(out_valid), 32'd0);
        tick(); #2;
        head("mrst_c2", 1'b1, 32'h0, 32'h0, 1'b0);
        tick(); #2;
        head("mrst_c3", 1'b1, 32'h4, 32'h1, 1'b0);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
